// File: rtl/gesture_pkg.sv
// gesture_pkg
//   Shared types and constants for the gesture-drone mode controller.
//   cmd_t   : decoded classifier command
//   state_t : armed / disarmed state
//   idx_width() : width of a mode index, never below one bit
package gesture_pkg;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_ON,
        CMD_OFF,
        CMD_MODE
    } cmd_t;

    typedef enum logic {
        ST_OFF,
        ST_ON
    } state_t;

    localparam int MODE_DEFAULT = 0;

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gesture_cmd_qualifier.sv
// gesture_cmd_qualifier
//   Decodes the classifier outputs into one command per cycle and only lets
//   a command through once it has been seen HOLD_CYCLES consecutive cycles.
//   Ports:
//     clock, reset       : rising-edge clock, async active-high reset
//     is_on, is_off      : arm / disarm requests (is_off has priority)
//     mode_req           : one-hot mode request; ambiguous patterns decode to NONE
//     accept             : single-cycle strobe, valid in the cycle the FSM should act
//     acc_cmd, acc_mode  : command (and mode index) being accepted
module gesture_cmd_qualifier
    import gesture_pkg::*;
#(
    parameter int NUM_MODES   = 4,
    parameter int HOLD_CYCLES = 3,
    localparam int MODE_W     = idx_width(NUM_MODES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 is_on,
    input  logic                 is_off,
    input  logic [NUM_MODES-1:0] mode_req,
    output logic                 accept,
    output cmd_t                 acc_cmd,
    output logic [MODE_W-1:0]    acc_mode
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    cmd_t              dec_cmd;
    cmd_t              cand_cmd;
    logic [MODE_W-1:0] dec_mode;
    logic [MODE_W-1:0] cand_mode;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              same;

    always_comb begin
        dec_mode = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (mode_req[i]) dec_mode = MODE_W'(i);
        end
        if (is_off)                        dec_cmd = CMD_OFF;
        else if (is_on)                    dec_cmd = CMD_ON;
        else if ($countones(mode_req) == 1) dec_cmd = CMD_MODE;
        else                               dec_cmd = CMD_NONE;
    end

    // A different mode index is a different command.
    assign same = (dec_cmd == cand_cmd) && (dec_cmd != CMD_NONE) &&
                  ((dec_cmd != CMD_MODE) || (dec_mode == cand_mode));

    always_comb begin
        hold_nxt = '0;
        if (same)
            hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);
        else if (dec_cmd != CMD_NONE)
            hold_nxt = HOLD_W'(1);
    end

    // Fire only on the transition into HOLD_MAX; a saturated counter that
    // stays saturated is the same command still being held.
    assign accept   = (hold_nxt == HOLD_MAX) && !(same && (hold_cnt == HOLD_MAX));
    assign acc_cmd  = dec_cmd;
    assign acc_mode = dec_mode;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand_cmd  <= CMD_NONE;
            cand_mode <= '0;
            hold_cnt  <= '0;
        end else begin
            cand_cmd  <= dec_cmd;
            cand_mode <= dec_mode;
            hold_cnt  <= hold_nxt;
        end
    end

endmodule

// File: rtl/gesture_mode_state.sv
// gesture_mode_state
//   Armed/disarmed state and flight mode for the gesture-drone controller,
//   driven by qualified classifier commands, with an inactivity auto-disarm.
//   Ports:
//     clock, reset   : rising-edge clock, async active-high reset
//     is_on, is_off  : arm / disarm requests
//     mode_req       : one-hot mode request
//     activity       : hand present; restarts the inactivity timer only
//     on_off_s       : 1 = armed
//     mode           : current mode index
//     changed        : one-cycle pulse when on_off_s or mode changes
//     timeout_pulse  : one-cycle pulse on auto-disarm
module gesture_mode_state
    import gesture_pkg::*;
#(
    parameter int NUM_MODES      = 4,
    parameter int HOLD_CYCLES    = 3,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter bit TIMEOUT_EN     = 1'b1,
    localparam int MODE_W        = idx_width(NUM_MODES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 is_on,
    input  logic                 is_off,
    input  logic [NUM_MODES-1:0] mode_req,
    input  logic                 activity,
    output logic                 on_off_s,
    output logic [MODE_W-1:0]    mode,
    output logic                 changed,
    output logic                 timeout_pulse
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_RST = MODE_W'(MODE_DEFAULT);

    state_t            state, state_nxt;
    logic [MODE_W-1:0] mode_nxt;
    logic              changed_nxt;
    logic              tpulse_nxt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;

    logic              accept;
    cmd_t              acc_cmd;
    logic [MODE_W-1:0] acc_mode;

    gesture_cmd_qualifier #(
        .NUM_MODES   (NUM_MODES),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_qual (
        .clock    (clock),
        .reset    (reset),
        .is_on    (is_on),
        .is_off   (is_off),
        .mode_req (mode_req),
        .accept   (accept),
        .acc_cmd  (acc_cmd),
        .acc_mode (acc_mode)
    );

    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode;
        changed_nxt = 1'b0;
        tpulse_nxt  = 1'b0;
        tmo_nxt     = '0;
        case (state)
            ST_OFF: begin
                if (accept && acc_cmd == CMD_ON) begin
                    state_nxt   = ST_ON;
                    mode_nxt    = MODE_RST;
                    changed_nxt = 1'b1;
                end
            end
            ST_ON: begin
                // Any accepted command (even a no-op) counts as activity,
                // so it also beats a timeout landing on the same edge.
                if (accept) begin
                    if (acc_cmd == CMD_OFF) begin
                        state_nxt   = ST_OFF;
                        mode_nxt    = MODE_RST;
                        changed_nxt = 1'b1;
                    end else if (acc_cmd == CMD_MODE && acc_mode != mode) begin
                        mode_nxt    = acc_mode;
                        changed_nxt = 1'b1;
                    end
                end else if (activity || !TIMEOUT_EN) begin
                    tmo_nxt = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt   = ST_OFF;
                    mode_nxt    = MODE_RST;
                    changed_nxt = 1'b1;
                    tpulse_nxt  = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            default: begin
                state_nxt = ST_OFF;
                mode_nxt  = MODE_RST;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_OFF;
            mode          <= MODE_RST;
            changed       <= 1'b0;
            timeout_pulse <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            mode          <= mode_nxt;
            changed       <= changed_nxt;
            timeout_pulse <= tpulse_nxt;
            tmo_cnt       <= tmo_nxt;
        end
    end

    assign on_off_s = (state == ST_ON);

endmodule
